// File: rtl/room_state.sv
// Shared room and direction types for the adventure room FSM and its neighbours.
package room_state;

  typedef enum logic [2:0] {
    r_1 = 3'd0,  // cave (start)
    r_2 = 3'd1,  // tunnel
    r_3 = 3'd2,  // sword stash
    r_4 = 3'd3,  // river
    r_5 = 3'd4,  // dragon den
    r_6 = 3'd5,  // victory
    r_7 = 3'd6   // graveyard
  } room_state_type;

  // Values double as bit positions in the packed button vector.
  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_S = 2'd1,
    DIR_E = 2'd2,
    DIR_W = 2'd3
  } dir_type;

  localparam int         NUM_DIRS = 4;
  localparam logic [7:0] MOVE_MAX = 8'd255;

endpackage

// File: rtl/room_machine_dir_edge.sv
// Button rising-edge detector; emits a pulse only when exactly one direction rose.
module dir_edge
  import room_state::*;
#(
  parameter int W = NUM_DIRS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] btn,
  output logic [W-1:0] pulse,
  output logic         valid
);

  logic [W-1:0] hist;
  logic [W-1:0] rise;

  // History clears in reset so a button held across reset release reads as a press.
  always_ff @(posedge clk) begin
    if (!reset) hist <= '0;
    else        hist <= btn;
  end

  for (genvar i = 0; i < W; i++) begin : g_rise
    assign rise[i] = btn[i] & ~hist[i];
  end

  assign valid = $onehot(rise);
  assign pulse = valid ? rise : '0;

endmodule

// File: rtl/room_machine.sv
// Room FSM with accepted-move counter; win/dead are registered decodes of the room.
module room_machine
  import room_state::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           north,
  input  logic           south,
  input  logic           east,
  input  logic           west,
  input  logic           founded_sword,
  output room_state_type room,
  output logic           win,
  output logic           dead,
  output logic [7:0]     move_count
);

  logic [NUM_DIRS-1:0] btn;
  logic [NUM_DIRS-1:0] pulse;
  logic                valid;
  room_state_type      room_next;
  logic                move;

  assign btn = {west, east, south, north};

  dir_edge #(.W(NUM_DIRS)) u_dir_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .pulse (pulse),
    .valid (valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      room       <= r_1;
      win        <= 1'b0;
      dead       <= 1'b0;
      move_count <= '0;
    end else begin
      room <= room_next;
      win  <= (room_next == r_6);
      dead <= (room_next == r_7);
      if (move && move_count != MOVE_MAX) move_count <= move_count + 8'd1;
    end
  end

  // pulse is already gated by valid, so at most one bit can be set here.
  always_comb begin
    room_next = room;
    move      = 1'b0;
    unique case (room)
      r_1: if (pulse[DIR_E]) begin room_next = r_2; move = 1'b1; end
      r_2: begin
        if (pulse[DIR_W])      begin room_next = r_1; move = 1'b1; end
        else if (pulse[DIR_S]) begin room_next = r_4; move = 1'b1; end
      end
      r_3: if (pulse[DIR_E]) begin room_next = r_4; move = 1'b1; end
      r_4: begin
        if (pulse[DIR_N])      begin room_next = r_2; move = 1'b1; end
        else if (pulse[DIR_W]) begin room_next = r_3; move = 1'b1; end
        else if (pulse[DIR_E]) begin room_next = r_5; move = 1'b1; end
      end
      // Dragon den resolves in one cycle and is not a player move.
      r_5: room_next = founded_sword ? r_6 : r_7;
      r_6, r_7: room_next = room;
      default: room_next = r_1;
    endcase
  end

endmodule
